int_tlp_gen: RTL and testbench

INT_TLP_GEN -- requirements
Module: int_tlp_gen

---
 rtl/int_tlp_gen.sv | 205 ++++++++++++++++++++
 tb/tb_int_tlp_gen.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_tlp_gen.sv
// int_tlp_gen: turns cfg_interrupt requests into MSI MemWr or INTx
// Assert/Deassert message TLPs on a 128-bit valid/ready beat stream.
module int_tlp_gen #(
  parameter logic [2:0] MSI_TC        = 3'd0,
  parameter bit         INTX_SUPPRESS = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_interrupt_n,
  input  logic         cfg_interrupt_assert_n,
  input  logic [7:0]   cfg_interrupt_di,
  output logic         cfg_interrupt_rdy_n,
  input  logic         msi_enable,
  input  logic [2:0]   msi_mmenable,
  input  logic [63:0]  msi_addr,
  input  logic [15:0]  msi_data,
  input  logic         intx_disable,
  input  logic [15:0]  req_id,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [127:0] tx_data,
  output logic         tx_sop,
  output logic         tx_eop,
  output logic [3:0]   tx_dwen,
  output logic         intx_asserted
);

  typedef enum logic [2:0] {
    IDLE, MSI_B0, MSI_B1, MSG, ACK
  } state_t;

  state_t state, state_n;

  logic [7:0]  di_q;
  logic        assert_n_q;
  logic        msi_en_q;
  logic [2:0]  mme_q;
  logic [63:2] addr_q;
  logic [15:0] data_q;
  logic        intx_dis_q;
  logic [15:0] req_id_q;

  logic        take;
  logic        accept;
  logic [7:0]  s_di;
  logic        s_assert_n;
  logic        s_msi_en;
  logic [2:0]  s_mme;
  logic [63:2] s_addr;
  logic [15:0] s_data;
  logic        s_intx_dis;
  logic [15:0] s_req_id;
  logic        unused_addr_bits;

  // The accepting cycle sees the same values the config regs capture.
  assign take       = (state == IDLE) && !cfg_interrupt_n;
  assign accept     = tx_valid && tx_ready;
  assign s_di       = take ? cfg_interrupt_di : di_q;
  assign s_assert_n = take ? cfg_interrupt_assert_n : assert_n_q;
  assign s_msi_en   = take ? msi_enable : msi_en_q;
  assign s_mme      = take ? msi_mmenable : mme_q;
  assign s_addr     = take ? msi_addr[63:2] : addr_q;
  assign s_data     = take ? msi_data : data_q;
  assign s_intx_dis = take ? intx_disable : intx_dis_q;
  assign s_req_id   = take ? req_id : req_id_q;
  assign unused_addr_bits = ^msi_addr[1:0];

  logic [2:0]  nbits;
  logic [15:0] mask;
  logic [15:0] eff;
  logic [31:0] payload;
  logic [31:0] addr_lo;
  logic [31:0] addr_hi;
  logic        is64;
  logic        level;
  logic [31:0] hdr_mw;
  logic [31:0] hdr_msg;
  logic [31:0] dw1_mw;
  logic [31:0] dw1_msg;

  assign nbits   = (s_mme > 3'd5) ? 3'd5 : s_mme;
  assign mask    = ~(16'hFFFF << nbits);
  assign eff     = (s_data & ~mask) | ({8'h00, s_di} & mask);
  assign payload = {16'h0000, eff};
  assign addr_lo = {s_addr[31:2], 2'b00};
  assign addr_hi = s_addr[63:32];
  assign is64    = |addr_hi;
  assign level   = !s_assert_n;
  assign hdr_mw  = {2'b01, is64, 5'b00000, 1'b0, MSI_TC,
                    4'h0, 2'b00, 2'b00, 2'b00, 10'd1};
  assign hdr_msg = {3'b001, 5'b10100, 24'h000000};
  assign dw1_mw  = {s_req_id, 8'h00, 4'h0, 4'hF};
  assign dw1_msg = {s_req_id, 8'h00, level ? 8'h20 : 8'h24};

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (!cfg_interrupt_n) begin
          if (msi_enable)
            state_n = MSI_B0;
          else if (intx_disable)
            state_n = ACK;
          else if (INTX_SUPPRESS && (level == intx_asserted))
            state_n = ACK;
          else
            state_n = MSG;
        end
      end
      MSI_B0: if (accept) state_n = is64 ? MSI_B1 : ACK;
      MSI_B1: if (accept) state_n = ACK;
      MSG:    if (accept) state_n = ACK;
      ACK:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  logic         valid_d;
  logic         sop_d;
  logic         eop_d;
  logic [3:0]   dwen_d;
  logic [127:0] data_d;
  logic         rdy_n_d;

  // Beat contents follow the next state so the outputs stay registered.
  always_comb begin
    valid_d = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    dwen_d  = 4'b0000;
    data_d  = '0;
    rdy_n_d = 1'b1;
    unique case (state_n)
      MSI_B0: begin
        valid_d = 1'b1;
        sop_d   = 1'b1;
        eop_d   = !is64;
        dwen_d  = 4'b1111;
        data_d  = is64 ? {addr_lo, addr_hi, dw1_mw, hdr_mw}
                       : {payload, addr_lo, dw1_mw, hdr_mw};
      end
      MSI_B1: begin
        valid_d = 1'b1;
        eop_d   = 1'b1;
        dwen_d  = 4'b0001;
        data_d  = {96'h0, payload};
      end
      MSG: begin
        valid_d = 1'b1;
        sop_d   = 1'b1;
        eop_d   = 1'b1;
        dwen_d  = 4'b1111;
        data_d  = {64'h0, dw1_msg, hdr_msg};
      end
      ACK:     rdy_n_d = 1'b0;
      default: rdy_n_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      tx_valid            <= 1'b0;
      tx_sop              <= 1'b0;
      tx_eop              <= 1'b0;
      tx_dwen             <= 4'b0000;
      tx_data             <= '0;
      cfg_interrupt_rdy_n <= 1'b1;
      intx_asserted       <= 1'b0;
    end else begin
      state               <= state_n;
      tx_valid            <= valid_d;
      tx_sop              <= sop_d;
      tx_eop              <= eop_d;
      tx_dwen             <= dwen_d;
      tx_data             <= data_d;
      cfg_interrupt_rdy_n <= rdy_n_d;
      if (state == MSG && accept)
        intx_asserted <= !assert_n_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      di_q       <= '0;
      assert_n_q <= 1'b1;
      msi_en_q   <= 1'b0;
      mme_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      intx_dis_q <= 1'b0;
      req_id_q   <= '0;
    end else if (take) begin
      di_q       <= cfg_interrupt_di;
      assert_n_q <= cfg_interrupt_assert_n;
      msi_en_q   <= msi_enable;
      mme_q      <= msi_mmenable;
      addr_q     <= msi_addr[63:2];
      data_q     <= msi_data;
      intx_dis_q <= intx_disable;
      req_id_q   <= req_id;
    end
  end

endmodule

// File: tb/tb_int_tlp_gen.sv
// tb_int_tlp_gen: table vectors, hand sequences and randomized requests
// checked against a behavioural model of the interrupt-to-TLP rules.
module tb_int_tlp_gen;

  localparam logic [2:0] TB_TC = 3'd0;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_interrupt_n;
  logic         cfg_interrupt_assert_n;
  logic [7:0]   cfg_interrupt_di;
  logic         cfg_interrupt_rdy_n;
  logic         msi_enable;
  logic [2:0]   msi_mmenable;
  logic [63:0]  msi_addr;
  logic [15:0]  msi_data;
  logic         intx_disable;
  logic [15:0]  req_id;
  logic         tx_valid;
  logic         tx_ready;
  logic [127:0] tx_data;
  logic         tx_sop;
  logic         tx_eop;
  logic [3:0]   tx_dwen;
  logic         intx_asserted;

  int_tlp_gen #(.MSI_TC(TB_TC), .INTX_SUPPRESS(1'b1)) dut (
    .clk(clk), .rst(rst),
    .cfg_interrupt_n(cfg_interrupt_n),
    .cfg_interrupt_assert_n(cfg_interrupt_assert_n),
    .cfg_interrupt_di(cfg_interrupt_di),
    .cfg_interrupt_rdy_n(cfg_interrupt_rdy_n),
    .msi_enable(msi_enable), .msi_mmenable(msi_mmenable),
    .msi_addr(msi_addr), .msi_data(msi_data),
    .intx_disable(intx_disable), .req_id(req_id),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_dwen(tx_dwen),
    .intx_asserted(intx_asserted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        msi_en;
    logic        assert_n;
    logic        intx_dis;
    logic [2:0]  mme;
    logic [63:0] addr;
    logic [15:0] data;
    logic [7:0]  di;
    logic [15:0] rid;
  } req_t;

  typedef struct {
    logic [127:0] data;
    logic         sop;
    logic         eop;
    logic [3:0]   dwen;
  } beat_t;

  typedef struct {
    req_t        r;
    int          beats;
    logic [31:0] dw0, dw1, dw2, dw3;
    logic        intx;
  } vec_t;

  int    tests = 0;
  int    fails = 0;
  logic  model_intx = 1'b0;
  beat_t got_q[$];
  beat_t exp_q[$];
  int    rdy_at, first_v, holds;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic rdy_fn(input int cyc, input int stall,
                                  input bit rnd);
    if (cyc < stall) return 1'b0;
    if (rnd) return 1'($urandom % 2);
    return 1'b1;
  endfunction

  task automatic apply_cfg(input req_t r);
    msi_enable             = r.msi_en;
    cfg_interrupt_assert_n = r.assert_n;
    intx_disable           = r.intx_dis;
    msi_mmenable           = r.mme;
    msi_addr               = r.addr;
    msi_data               = r.data;
    cfg_interrupt_di       = r.di;
    req_id                 = r.rid;
  endtask

  task automatic junk_cfg();
    msi_enable             = 1'($urandom % 2);
    cfg_interrupt_assert_n = 1'($urandom % 2);
    intx_disable           = 1'($urandom % 2);
    msi_mmenable           = 3'($urandom);
    msi_addr               = {$urandom, $urandom};
    msi_data               = 16'($urandom);
    cfg_interrupt_di       = 8'($urandom);
    req_id                 = 16'($urandom);
  endtask

  // Called in the drive window just after a rising edge.
  task automatic do_req(input req_t r, input int stall, input bit rnd);
    bit    prev_hold;
    beat_t pb;
    got_q.delete();
    rdy_at = -1; first_v = -1; holds = 0; prev_hold = 0;
    pb = '{default: '0};
    apply_cfg(r);
    cfg_interrupt_n = 1'b0;
    tx_ready = rdy_fn(0, stall, rnd);
    for (int cyc = 0; cyc < 80 && rdy_at < 0; cyc++) begin
      @(negedge clk);
      if (prev_hold) begin
        holds++;
        chk("hold_data", tx_data, pb.data);
        chk("hold_ctrl", 128'({tx_valid, tx_sop, tx_eop, tx_dwen}),
            128'({1'b1, pb.sop, pb.eop, pb.dwen}));
      end
      if (tx_valid && first_v < 0) first_v = cyc;
      if (tx_valid && tx_ready)
        got_q.push_back('{tx_data, tx_sop, tx_eop, tx_dwen});
      prev_hold = tx_valid && !tx_ready;
      pb = '{tx_data, tx_sop, tx_eop, tx_dwen};
      if (!cfg_interrupt_rdy_n) rdy_at = cyc;
      @(posedge clk); #1;
      if (rdy_at >= 0) cfg_interrupt_n = 1'b1;
      if (cyc == 0) junk_cfg();
      tx_ready = rdy_fn(cyc + 1, stall, rnd);
    end
    chk("rdy_seen", 128'(rdy_at >= 0), 128'(1));
    cfg_interrupt_n = 1'b1;
    @(negedge clk);
    chk("rdy_single", 128'(cfg_interrupt_rdy_n), 128'(1));
    chk("idle_no_valid", 128'(tx_valid), 128'(0));
    @(posedge clk); #1;
  endtask

  task automatic ref_model(input req_t r);
    int          n, m;
    logic [15:0] eff;
    logic [31:0] pay, lo, hi, dw0, dw1;
    logic        lvl;
    exp_q.delete();
    if (r.msi_en) begin
      n   = (r.mme > 3'd5) ? 5 : int'(r.mme);
      m   = 1 << n;
      eff = 16'(int'(r.data) - (int'(r.data) % m) + (int'(r.di) % m));
      pay = {16'h0, eff};
      lo  = {r.addr[31:2], 2'b00};
      hi  = r.addr[63:32];
      dw1 = {r.rid, 16'h000F};
      dw0 = ((hi == 0) ? 32'h4000_0001 : 32'h6000_0001)
            | (32'(TB_TC) << 20);
      if (hi == 0) begin
        exp_q.push_back('{{pay, lo, dw1, dw0}, 1'b1, 1'b1, 4'hF});
      end else begin
        exp_q.push_back('{{lo, hi, dw1, dw0}, 1'b1, 1'b0, 4'hF});
        exp_q.push_back('{{96'h0, pay}, 1'b0, 1'b1, 4'h1});
      end
    end else begin
      lvl = !r.assert_n;
      if (!r.intx_dis && lvl != model_intx) begin
        dw1 = {r.rid, 8'h00, lvl ? 8'h20 : 8'h24};
        exp_q.push_back('{{64'h0, dw1, 32'h3400_0000},
                          1'b1, 1'b1, 4'hF});
        model_intx = lvl;
      end
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_beats"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_data"}, got_q[i].data, exp_q[i].data);
      chk({tag, "_ctrl"}, 128'({got_q[i].sop, got_q[i].eop, got_q[i].dwen}),
          128'({exp_q[i].sop, exp_q[i].eop, exp_q[i].dwen}));
    end
    chk({tag, "_intx"}, 128'(intx_asserted), 128'(model_intx));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[10];
  req_t rq;
  bit   bad;

  initial begin
    tbl[0] = '{'{1'b1, 1'b1, 1'b0, 3'd3, 64'h0000_0000_FEE0_1000, 16'h4000,
                 8'h05, 16'h0108}, 1, 32'h4000_0001, 32'h0108_000F,
               32'hFEE0_1000, 32'h0000_4005, 1'b0};
    tbl[1] = '{'{1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 16'h0, 8'h00, 16'h0108},
               1, 32'h3400_0000, 32'h0108_0020, 32'h0, 32'h0, 1'b1};
    tbl[2] = '{'{1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 16'h0, 8'h00, 16'h0108},
               0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1};
    tbl[3] = '{'{1'b0, 1'b1, 1'b0, 3'd0, 64'h0, 16'h0, 8'h00, 16'h0108},
               1, 32'h3400_0000, 32'h0108_0024, 32'h0, 32'h0, 1'b0};
    tbl[4] = '{'{1'b0, 1'b1, 1'b0, 3'd0, 64'h0, 16'h0, 8'h00, 16'h0108},
               0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
    tbl[5] = '{'{1'b0, 1'b0, 1'b1, 3'd0, 64'h0, 16'h0, 8'h00, 16'h0108},
               0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
    tbl[6] = '{'{1'b1, 1'b1, 1'b0, 3'd7, 64'h0000_0000_1234_5677, 16'hABFF,
                 8'hE3, 16'h0A10}, 1, 32'h4000_0001, 32'h0A10_000F,
               32'h1234_5674, 32'h0000_ABE3, 1'b0};
    tbl[7] = '{'{1'b1, 1'b1, 1'b0, 3'd0, 64'h0000_0000_FEE0_0000, 16'h1234,
                 8'hFF, 16'h0108}, 1, 32'h4000_0001, 32'h0108_000F,
               32'hFEE0_0000, 32'h0000_1234, 1'b0};
    tbl[8] = '{'{1'b1, 1'b0, 1'b1, 3'd1, 64'h0000_0000_FEE0_0004, 16'h5550,
                 8'h03, 16'h0108}, 1, 32'h4000_0001, 32'h0108_000F,
               32'hFEE0_0004, 32'h0000_5551, 1'b0};
    tbl[9] = '{'{1'b1, 1'b1, 1'b0, 3'd5, 64'h0000_0000_FEE0_0008, 16'hFFFF,
                 8'h00, 16'h0108}, 1, 32'h4000_0001, 32'h0108_000F,
               32'hFEE0_0008, 32'h0000_FFE0, 1'b0};

    rst = 1'b1; cfg_interrupt_n = 1'b1; tx_ready = 1'b0;
    apply_cfg(tbl[0].r);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 128'(tx_valid), 128'(0));
    chk("rst_rdy_n", 128'(cfg_interrupt_rdy_n), 128'(1));
    chk("rst_ctrl", 128'({tx_sop, tx_eop, tx_dwen}), 128'(0));
    chk("rst_data", tx_data, 128'(0));
    chk("rst_intx", 128'(intx_asserted), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      ref_model(tbl[i].r);
      do_req(tbl[i].r, 0, 1'b0);
      chk($sformatf("vec%0d_beats", i), 128'(got_q.size()),
          128'(tbl[i].beats));
      if (tbl[i].beats > 0 && got_q.size() > 0) begin
        chk($sformatf("vec%0d_dw0", i), 128'(got_q[0].data[31:0]),
            128'(tbl[i].dw0));
        chk($sformatf("vec%0d_dw1", i), 128'(got_q[0].data[63:32]),
            128'(tbl[i].dw1));
        chk($sformatf("vec%0d_dw2", i), 128'(got_q[0].data[95:64]),
            128'(tbl[i].dw2));
        chk($sformatf("vec%0d_dw3", i), 128'(got_q[0].data[127:96]),
            128'(tbl[i].dw3));
        chk($sformatf("vec%0d_first_valid", i), 128'(first_v), 128'(1));
      end else begin
        chk($sformatf("vec%0d_no_valid", i), 128'(first_v), 128'(-1));
      end
      chk($sformatf("vec%0d_latency", i), 128'(rdy_at),
          128'((tbl[i].beats == 0) ? 1 : 1 + tbl[i].beats));
      chk($sformatf("vec%0d_intx", i), 128'(intx_asserted),
          128'(tbl[i].intx));
      cmp_model($sformatf("vec%0d_model", i));
    end

    // 64-bit MSI with downstream stalled for three cycles.
    rq = '{1'b1, 1'b1, 1'b0, 3'd3, 64'h0000_0001_0000_0040, 16'h4000,
           8'h05, 16'h0108};
    do_req(rq, 4, 1'b0);
    chk("msi64_beats", 128'(got_q.size()), 128'(2));
    if (got_q.size() == 2) begin
      chk("msi64_b0", got_q[0].data,
          {32'h0000_0040, 32'h0000_0001, 32'h0108_000F, 32'h6000_0001});
      chk("msi64_b0_ctrl", 128'({got_q[0].sop, got_q[0].eop, got_q[0].dwen}),
          128'(6'b10_1111));
      chk("msi64_b1", got_q[1].data, {96'h0, 32'h0000_4005});
      chk("msi64_b1_ctrl", 128'({got_q[1].sop, got_q[1].eop, got_q[1].dwen}),
          128'(6'b01_0001));
    end
    chk("msi64_holds", 128'(holds), 128'(3));
    chk("msi64_latency", 128'(rdy_at), 128'(6));

    for (int k = 0; k < 40; k++) begin
      rq.msi_en   = 1'($urandom % 2);
      rq.assert_n = 1'($urandom % 2);
      rq.intx_dis = ($urandom % 4) == 0;
      rq.mme      = 3'($urandom);
      rq.addr     = {($urandom % 2) ? 32'h0 : $urandom, $urandom};
      rq.data     = 16'($urandom);
      rq.di       = 8'($urandom);
      rq.rid      = 16'($urandom);
      ref_model(rq);
      do_req(rq, int'($urandom % 3), 1'b1);
      cmp_model($sformatf("rand%0d", k));
    end

    // Leave INTx asserted, then reset in the middle of a 64-bit MSI.
    rq = '{1'b0, 1'b1, 1'b0, 3'd0, 64'h0, 16'h0, 8'h00, 16'h0200};
    ref_model(rq);
    do_req(rq, 0, 1'b0);
    cmp_model("pre_rst_deassert");
    rq.assert_n = 1'b0;
    ref_model(rq);
    do_req(rq, 0, 1'b0);
    cmp_model("pre_rst_assert");

    rq = '{1'b1, 1'b1, 1'b0, 3'd2, 64'h0000_00AB_FEE0_0010, 16'h7000,
           8'h02, 16'h0300};
    apply_cfg(rq);
    cfg_interrupt_n = 1'b0;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    @(negedge clk);
    chk("b1_pending", 128'({tx_valid, tx_sop, tx_eop, tx_dwen}),
        128'(7'b1_0_1_0001));
    @(posedge clk); #1;
    rst = 1'b1;
    cfg_interrupt_n = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 128'(tx_valid), 128'(0));
    chk("rst_mid_ctrl", 128'({tx_sop, tx_eop, tx_dwen}), 128'(0));
    chk("rst_mid_data", tx_data, 128'(0));
    chk("rst_mid_intx", 128'(intx_asserted), 128'(0));
    model_intx = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (!cfg_interrupt_rdy_n || tx_valid) bad = 1'b1;
    end
    chk("rst_mid_no_ack", 128'(bad), 128'(0));
    @(posedge clk); #1;
    tx_ready = 1'b1;

    ref_model(rq);
    do_req(rq, 0, 1'b0);
    cmp_model("post_rst_msi");
    chk("post_rst_latency", 128'(rdy_at), 128'(3));
    rq = '{1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 16'h0, 8'h00, 16'h0400};
    ref_model(rq);
    do_req(rq, 0, 1'b0);
    cmp_model("post_rst_assert");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
